// File: rtl/enemy_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : enemy_slot_scheduler
// Purpose  : Per-frame enemy slot scan; blood/respawn, score, contact damage,
//            sharing one external attack hit-test unit over req/ack.
// Revision : 1.0  initial release
// ============================================================================
module enemy_slot_scheduler #(
    parameter int ENEMY_NUM       = 4,
    parameter int IDX_W           = $clog2(ENEMY_NUM),
    parameter int RESPAWN_TIME    = 100,
    parameter int ENEMY_MAX_BLOOD = 100,
    parameter int PLAYER_DAMAGE   = 50,
    parameter int ENEMY_DAMAGE    = 10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 game_frame_clk_rising_edge,
    input  logic                 Attack_On,
    input  logic [ENEMY_NUM-1:0] Enemy_Contact,
    output logic                 Chk_Req,
    output logic [IDX_W-1:0]     Chk_Idx,
    input  logic                 Chk_Ack,
    input  logic                 Chk_Hit,
    output logic [ENEMY_NUM-1:0] Enemy_Alive,
    output logic [7:0]           Score,
    output logic [9:0]           Enemy_Total_Damage,
    output logic                 Busy,
    output logic                 Scan_Done,
    output logic                 Frame_Overrun
);

    localparam int         CNT_W       = $clog2(RESPAWN_TIME + 1);
    localparam logic [9:0] DMG_SAT_LIM = 10'(1023 - ENEMY_DAMAGE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SLOT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic                 atk_s;
    logic [ENEMY_NUM-1:0] con_s;
    logic [6:0]           blood [ENEMY_NUM];
    logic [CNT_W-1:0]     cnt   [ENEMY_NUM];

    logic       slot_dead;
    logic       last_slot;
    logic       advance;
    logic [7:0] hit_diff;

    // One extra bit so an over-large hit shows up as a borrow we can clamp.
    assign hit_diff  = {1'b0, blood[idx]} - 8'(PLAYER_DAMAGE);
    assign slot_dead = (blood[idx] == 7'd0);
    assign last_slot = (idx == IDX_W'(ENEMY_NUM - 1));

    always_comb begin
        advance = 1'b0;
        if (state == S_SLOT)
            advance = slot_dead || !atk_s;
        else if (state == S_CHECK)
            advance = Chk_Ack && Chk_Req;
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENEMY_NUM; gi++) begin : g_alive
            assign Enemy_Alive[gi] = (blood[gi] != 7'd0);
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < ENEMY_NUM; i++) begin
                blood[i] <= 7'(ENEMY_MAX_BLOOD);
                cnt[i]   <= '0;
            end
            state              <= S_IDLE;
            idx                <= '0;
            atk_s              <= 1'b0;
            con_s              <= '0;
            Score              <= 8'd0;
            Enemy_Total_Damage <= 10'd0;
            Chk_Req            <= 1'b0;
            Chk_Idx            <= '0;
            Busy               <= 1'b0;
            Scan_Done          <= 1'b0;
            Frame_Overrun      <= 1'b0;
        end else begin
            Scan_Done <= 1'b0;
            if (game_frame_clk_rising_edge && state != S_IDLE)
                Frame_Overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (game_frame_clk_rising_edge) begin
                        atk_s <= Attack_On;
                        con_s <= Enemy_Contact;
                        idx   <= '0;
                        Busy  <= 1'b1;
                        state <= S_SLOT;
                    end
                end
                S_SLOT: begin
                    if (slot_dead) begin
                        if (cnt[idx] == CNT_W'(RESPAWN_TIME - 1)) begin
                            blood[idx] <= 7'(ENEMY_MAX_BLOOD);
                            cnt[idx]   <= '0;
                        end else begin
                            cnt[idx] <= cnt[idx] + 1'b1;
                        end
                    end else begin
                        if (con_s[idx]) begin
                            if (Enemy_Total_Damage > DMG_SAT_LIM)
                                Enemy_Total_Damage <= 10'd1023;
                            else
                                Enemy_Total_Damage <= Enemy_Total_Damage + 10'(ENEMY_DAMAGE);
                        end
                        if (atk_s) begin
                            Chk_Req <= 1'b1;
                            Chk_Idx <= idx;
                            state   <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (Chk_Ack && Chk_Req) begin
                        Chk_Req <= 1'b0;
                        if (Chk_Hit) begin
                            blood[idx] <= hit_diff[7] ? 7'd0 : hit_diff[6:0];
                            cnt[idx]   <= '0;
                            if (Score != 8'hFF)
                                Score <= Score + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (advance) begin
                if (last_slot) begin
                    state     <= S_DONE;
                    Scan_Done <= 1'b1;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= S_SLOT;
                end
            end
        end
    end

endmodule
`default_nettype wire
